// File: rtl/cla_serial_addsub.sv
// Nibble-serial adder/subtractor built around one 4-bit carry-lookahead slice.
// Operands are shifted LSB nibble first; the result is published on completion.
module cla_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NNIB = WIDTH / 4;
    localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [3:0] na, nb, g, p, s;
    logic [4:0] c;

    // 4-bit carry-lookahead slice on the current low nibble
    always_comb begin
        na   = a_q[3:0];
        nb   = b_q[3:0];
        g    = na & nb;
        p    = na ^ nb;
        c[0] = c_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
    end

    // Next-state and datapath update; subtract is a + ~b + ~Cin
    always_comb begin
        logic [WIDTH+3:0] wide;
        wide    = '0;
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? ~Cin : Cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wide  = {s, res_q};
                res_d = wide[WIDTH+3:4];
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                c_d   = c[4];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    sum_d   = wide[WIDTH+3:4];
                    carry_d = c[4];
                    ovf_d   = c[4] ^ c[3];
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Bench for cla_serial_addsub: arithmetic/latency model plus directed
// vectors, reset abort, start hold-off and back-to-back random traffic.
module tb_cla_serial_addsub;

    localparam int W    = 16;
    localparam int NNIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         Cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry, overflow;
    logic [W-1:0] sum;

    cla_serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a), .b(b), .Cin(Cin), .busy(busy), .done(done),
        .sum(sum), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Returns {overflow, carry, sum} from plain integer arithmetic
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x,
        input logic [W-1:0] y, input logic ci, input logic s);
        longint ux, uy, sx, sy, lc, ur, r;
        logic cy, ov;
        logic [W-1:0] sm;
        ux = x; uy = y; lc = ci;
        sx = $signed(x); sy = $signed(y);
        if (!s) begin
            ur = ux + uy + lc;
            r  = sx + sy + lc;
            cy = (ur >= (longint'(1) << W));
        end else begin
            ur = ux - uy - lc;
            r  = sx - sy - lc;
            cy = (ur >= 0);
        end
        sm = ur[W-1:0];
        ov = (r > ((longint'(1) << (W-1)) - 1))
          || (r < -(longint'(1) << (W-1)));
        return {ov, cy, sm};
    endfunction

    logic         m_busy = 1'b0, m_done = 1'b0;
    logic         m_carry = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic [W+1:0] m_pend = '0;
    int           m_left = 0;

    // Operation-level model: accept, wait NNIB cycles, publish, one idle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
            m_sum <= '0; m_carry <= 1'b0; m_ovf <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_ovf   <= m_pend[W+1];
                m_carry <= m_pend[W];
                m_sum   <= m_pend[W-1:0];
            end
        end else if (start) begin
            m_pend <= ref_op(a, b, Cin, sub);
            m_busy <= 1'b1;
            m_left <= NNIB;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("sum", sum, m_sum);
            check("carry", carry, m_carry);
            check("overflow", overflow, m_ovf);
        end
    end

    task automatic go(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic s);
        a = x; b = y; Cin = ci; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = int'(busy);
        while (done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end
    endtask

    task automatic run_dir(input string nm, input logic [W-1:0] x,
        input logic [W-1:0] y, input logic ci, input logic s,
        input logic [W-1:0] es, input logic ec, input logic eo);
        int lat, bc;
        go(x, y, ci, s);
        wait_done(lat, bc);
        check({nm, "_lat"}, lat, NNIB + 1);
        check({nm, "_busycyc"}, bc, NNIB);
        check({nm, "_sum"}, sum, es);
        check({nm, "_carry"}, carry, ec);
        check({nm, "_ovf"}, overflow, eo);
        @(negedge clk);
    endtask

    initial begin
        int n, ex, nd, last, guard;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        check("rst_ovf", overflow, 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);

        check("pin_add", ref_op(16'h1234, 16'h0FED, 1'b0, 1'b0),
              {2'b00, 16'h2221});
        check("pin_sub", ref_op(16'h8000, 16'h0001, 1'b0, 1'b1),
              {2'b11, 16'h7FFF});
        check("pin_addc", ref_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0),
              {2'b01, 16'hFFFF});

        run_dir("add0", 16'h1234, 16'h0FED, 0, 0, 16'h2221, 0, 0);
        run_dir("addw", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        run_dir("addv", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        run_dir("addc", 16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0);
        run_dir("subn", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        run_dir("subv", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
        run_dir("subb", 16'h0009, 16'h0000, 1, 1, 16'h0008, 1, 0);

        // Hold-off: operands change and start re-pulses during RUN
        go(16'h0006, 16'h0002, 0, 0);
        a = 16'hAAAA; b = 16'hAAAA; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 3;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("hold_lat", n, NNIB + 1);
        check("hold_sum", sum, 16'h0008);
        ex = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ex++;
        end
        check("hold_extra_done", ex, 0);

        // Reset on the second RUN edge aborts the operation
        go(16'h1111, 16'h2222, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        check("abort_carry", carry, 0);
        check("abort_ovf", overflow, 0);
        rst_n = 1'b1;
        ex = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ex++;
        end
        check("abort_no_done", ex, 0);
        run_dir("post", 16'h0003, 16'h000A, 0, 0, 16'h000D, 0, 0);

        // Back-to-back with start held high and inputs churning
        nd = 0; last = -1; guard = 0;
        start = 1'b1;
        while (nd < 1000 && guard < 1000 * (NNIB + 2) + 100) begin
            a   = W'($urandom);
            b   = W'($urandom);
            Cin = 1'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
            guard++;
            if (done) begin
                if (last >= 0) check("b2b_interval", cyc - last, NNIB + 2);
                last = cyc;
                nd++;
            end
        end
        start = 1'b0;
        check("b2b_count", nd, 1000);

        repeat (8) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_serial_addsub.md
Name: cla_serial_addsub

Overview:
- Nibble-serial WIDTH-bit adder/subtractor.
- Reuses a single 4-bit carry-lookahead slice, processing one nibble per clock, LSB nibble first.
- Accepts an operand pair on a start pulse and returns the result, carry/borrow and signed overflow with a one-cycle done pulse.
- Serves as the multi-cycle wide-arithmetic unit built on the 4-bit CLA datapath; subtraction is the inverse direction of the adder.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NNIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = add, 1 = subtract; latched at start
- a  input  WIDTH  operand A; latched at start
- b  input  WIDTH  operand B; latched at start
- Cin  input  1  add: carry-in; sub: borrow-in (1 = borrow); latched at start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  result register
- carry  output  1  add: carry-out; sub: 1 = no borrow (two's-complement carry)
- overflow  output  1  signed overflow of the operation

Behaviour:
- Reset: rst_n low at a rising edge forces IDLE, with busy=0, done=0, sum=0, carry=0, overflow=0, and clears internal nibble index, carry flop and shift registers. Reset wins over every other event, including mid-RUN. An aborted operation produces no done and leaves sum=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b (b is inverted when sub=1) and sub.
  - The initial carry is loaded as Cin when sub=0 and as ~Cin when sub=1.
  - nib index is set to 0 and the state moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge computes nibble[idx] with 4-bit CLA equations: g=a&b, p=a^b, c1..c4 from lookahead, s=p^{c3..c0}.
  - The nibble is written into the result shift register, c4 goes to the carry flop, and idx increments.
  - On the edge where idx=NNIB-1:
    - sum is loaded with the full assembled result.
    - carry is loaded with c4 of the top nibble.
    - overflow is loaded with c4^c3 of the top nibble.
    - The state moves to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE.
- Latency: start accepted at edge E0; busy=1 for the NNIB cycles after E0; done=1 in the cycle after edge E(NNIB). For WIDTH=16, done rises 4 edges after E0. Next start is accepted at the earliest in the IDLE cycle after done, so throughput is one operation per NNIB+2 cycles.
- start while in RUN or DONE is ignored and does not restart or queue.
- Inputs a, b, sub and Cin may change freely after E0 without affecting the result.
- sum, carry and overflow change only at completion or reset. They hold their values across IDLE, RUN and DONE of the next operation until that operation completes.
- Arithmetic, all modulo 2^WIDTH:
  - Add: sum = a + b + Cin.
  - Sub: sum = a - b - Cin = a + ~b + ~Cin.
  - overflow: true signed overflow for both modes.

Test Plan:
- Add, WIDTH=16: a=0x1234, b=0x0FED, Cin=0, sub=0 -> done exactly 4 edges after accept; sum=0x2221, carry=0, overflow=0; busy high for exactly 4 cycles.
- Carry/overflow edges:
  - 0xFFFF+0x0001, Cin=0 -> sum=0x0000, carry=1, overflow=0.
  - 0x7FFF+0x0001 -> sum=0x8000, carry=0, overflow=1.
  - 0xFFFF+0xFFFF, Cin=1 -> sum=0xFFFF, carry=1, overflow=0.
- Subtract:
  - 0x0005-0x0007, Cin=0 -> sum=0xFFFE, carry=0, overflow=0.
  - 0x8000-0x0001, Cin=0 -> sum=0x7FFF, carry=1, overflow=1.
  - 0x0009-0x0000, Cin=1 -> sum=0x0008, carry=1, overflow=0.
- Operand hold-off: start 0x0006+0x0002, then change a/b to 0xAAAA and re-pulse start during RUN -> a single done, sum=0x0008. The second start is ignored and no second done follows.
- Reset mid-op: start 0x1111+0x2222, drive rst_n=0 at the 2nd RUN edge -> busy=0, done never asserts, sum=0, carry=0, overflow=0. A new op 0x0003+0x000A then gives sum=0x000D normally.
- Back-to-back: hold start=1 continuously -> operations complete every 6 cycles (NNIB+2). sum/carry stay stable between completions. Compare against a+b+Cin / a-b-Cin for 1000 random vectors in both modes.
